// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO controller wrapped around an external simple dual-port BRAM.
// Hides the BRAM's 1-cycle registered read so a primed stream moves one word per cycle.
module bram_fifo_ctrl #(
    parameter int DATAW = 32,
    parameter int ADDRW = 7,
    parameter int DEPTH = 128
) (
    input  logic             i_clk,
    input  logic             i_rest,
    input  logic             i_flush,
    input  logic             i_wvalid,
    input  logic [DATAW-1:0] i_wdata,
    output logic             o_wready,
    output logic             o_rvalid,
    output logic [DATAW-1:0] o_rdata,
    input  logic             i_rready,
    output logic [ADDRW:0]   o_level,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_bram_rest_n,
    output logic             o_bram_ren,
    output logic             o_bram_wen,
    output logic [ADDRW-1:0] o_bram_raddr,
    output logic [ADDRW-1:0] o_bram_waddr,
    output logic [DATAW-1:0] o_bram_din,
    input  logic [DATAW-1:0] i_bram_dout
);

    localparam logic [ADDRW:0] LP_DEPTH = DEPTH[ADDRW:0];

    logic [ADDRW-1:0] r_wptr;
    logic [ADDRW-1:0] r_rptr;
    logic [ADDRW:0]   r_memcnt;
    logic             r_outvalid;

    logic             w_wready;
    logic             w_rvalid;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [ADDRW:0]   w_level;

    assign w_wready = ~i_rest & (r_memcnt != LP_DEPTH);
    assign w_rvalid = r_outvalid & ~i_rest;
    assign w_push   = i_wvalid & w_wready & ~i_flush;
    assign w_pop    = w_rvalid & i_rready & ~i_flush;

    // A read is only issued when the output slot is free or being vacated, so the
    // BRAM's held DOUT doubles as the output register while the consumer stalls.
    assign w_issue  = ~i_rest & ~i_flush & (r_memcnt != '0) & (~r_outvalid | w_pop);

    assign w_level  = i_rest ? '0 : (r_memcnt + {{ADDRW{1'b0}}, r_outvalid});

    always_ff @(posedge i_clk) begin
        if (i_rest || i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_memcnt   <= '0;
            r_outvalid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_memcnt <= r_memcnt + {{ADDRW{1'b0}}, w_push} - {{ADDRW{1'b0}}, w_issue};
            if (w_issue) begin
                r_outvalid <= 1'b1;
            end else if (w_pop) begin
                r_outvalid <= 1'b0;
            end
        end
    end

    assign o_wready      = w_wready;
    assign o_rvalid      = w_rvalid;
    assign o_rdata       = i_bram_dout;
    assign o_level       = w_level;
    assign o_empty       = (w_level == '0);
    assign o_full        = ~i_rest & (r_memcnt == LP_DEPTH);
    assign o_bram_rest_n = ~i_rest;
    assign o_bram_ren    = w_issue;
    assign o_bram_wen    = w_push;
    assign o_bram_raddr  = r_rptr;
    assign o_bram_waddr  = r_wptr;
    assign o_bram_din    = i_wdata;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural BRAM (1-cycle registered read,
// DOUT held until the next read enable).
module tb_bram_fifo_ctrl;

    localparam int DATAW = 32;
    localparam int ADDRW = 7;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             rest = 1'b1;
    logic             flush = 1'b0;
    logic             wvalid = 1'b1;
    logic [DATAW-1:0] wdata = '0;
    logic             wready;
    logic             rvalid;
    logic [DATAW-1:0] rdata;
    logic             rready = 1'b0;
    logic [ADDRW:0]   level;
    logic             empty;
    logic             full;
    logic             bram_rest_n;
    logic             bram_ren;
    logic             bram_wen;
    logic [ADDRW-1:0] bram_raddr;
    logic [ADDRW-1:0] bram_waddr;
    logic [DATAW-1:0] bram_din;
    logic [DATAW-1:0] bram_dout = '0;

    logic [DATAW-1:0] mem [0:DEPTH-1];
    logic [DATAW-1:0] sb [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DATAW(DATAW), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rest(rest), .i_flush(flush),
        .i_wvalid(wvalid), .i_wdata(wdata), .o_wready(wready),
        .o_rvalid(rvalid), .o_rdata(rdata), .i_rready(rready),
        .o_level(level), .o_empty(empty), .o_full(full),
        .o_bram_rest_n(bram_rest_n), .o_bram_ren(bram_ren), .o_bram_wen(bram_wen),
        .o_bram_raddr(bram_raddr), .o_bram_waddr(bram_waddr),
        .o_bram_din(bram_din), .i_bram_dout(bram_dout)
    );

    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_din;
        if (bram_ren) bram_dout <= mem[bram_raddr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: accepted writes feed the queue, every consumer handshake is checked in order.
    always @(negedge clk) begin
        logic [DATAW-1:0] e;
        if (rest || flush) begin
            sb.delete();
        end else begin
            if (rvalid && rready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rdata_order", 64'(rdata), 64'(e));
                end
            end
            if (wvalid && wready) sb.push_back(wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output int pops);
        pops = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            wvalid = 1'b0;
            rready = 1'b1;
            @(negedge clk);
            if (rvalid) pops++;
            if (empty) break;
        end
        rready = 1'b0;
    endtask

    initial begin
        int acc;
        int pops;
        int bubbles;
        int lvl_bad;
        int addr_bad;

        // Reset held 3 cycles with the producer pushing
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_wready", 64'(wready), 0);
            chk("rst_rvalid", 64'(rvalid), 0);
            chk("rst_level", 64'(level), 0);
            chk("rst_empty", 64'(empty), 1);
            chk("rst_wen", 64'(bram_wen), 0);
            chk("rst_bram_rest_n", 64'(bram_rest_n), 0);
        end
        step();
        rest = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_wready", 64'(wready), 1);
        chk("post_rst_bram_rest_n", 64'(bram_rest_n), 1);
        chk("post_rst_full", 64'(full), 0);

        // Single word, stalled consumer
        step();
        wvalid = 1'b1;
        wdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("single_wen", 64'(bram_wen), 1);
        chk("single_waddr", 64'(bram_waddr), 0);
        step();
        wvalid = 1'b0;
        @(negedge clk);
        chk("single_ren", 64'(bram_ren), 1);
        chk("single_raddr", 64'(bram_raddr), 0);
        chk("single_rvalid_c1", 64'(rvalid), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("single_rvalid", 64'(rvalid), 1);
            chk("single_rdata_hold", 64'(rdata), 64'h0000_0000_A5A5_0001);
            chk("single_level", 64'(level), 1);
        end
        step();
        rready = 1'b1;
        @(negedge clk);
        step();
        rready = 1'b0;
        @(negedge clk);
        chk("single_after_rvalid", 64'(rvalid), 0);
        chk("single_after_empty", 64'(empty), 1);

        // Streaming 300 words, pointers start at 1
        acc = 0; bubbles = 0; lvl_bad = 0; addr_bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            wvalid = 1'b1;
            wdata = 32'h5000_0000 + 32'(i);
            rready = 1'b1;
            @(negedge clk);
            if (wready) acc++;
            if (i >= 2) begin
                if (!rvalid) bubbles++;
                if (level != 8'd2) lvl_bad++;
            end
            if (bram_waddr != 7'((1 + i) % 128)) addr_bad++;
            if (i >= 1 && (!bram_ren || bram_raddr != 7'(i % 128))) addr_bad++;
        end
        chk("stream_accepted", 64'(acc), 300);
        chk("stream_bubbles", 64'(bubbles), 0);
        chk("stream_level", 64'(lvl_bad), 0);
        chk("stream_addr_wrap", 64'(addr_bad), 0);
        drain(pops);
        chk("stream_drain_pops", 64'(pops), 2);
        chk("stream_sb_empty", 64'(sb.size()), 0);
        chk("stream_empty", 64'(empty), 1);

        // Fill with consumer stalled
        acc = 0;
        for (int k = 0; k < 130; k++) begin
            step();
            wvalid = 1'b1;
            wdata = 32'h7000_0000 + 32'(k);
            rready = 1'b0;
            @(negedge clk);
            if (wready) acc++;
        end
        chk("fill_accepted", 64'(acc), 129);
        step();
        wvalid = 1'b0;
        @(negedge clk);
        chk("fill_full", 64'(full), 1);
        chk("fill_wready", 64'(wready), 0);
        chk("fill_level", 64'(level), 129);

        // Pop at full, then push into the freed slot
        step();
        rready = 1'b1;
        wvalid = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("full_pop_ren", 64'(bram_ren), 1);
        chk("full_pop_wready", 64'(wready), 0);
        step();
        rready = 1'b0;
        wvalid = 1'b1;
        wdata = 32'h7777_0000;
        @(negedge clk);
        chk("full_after_wready", 64'(wready), 1);
        chk("full_after_level", 64'(level), 128);
        chk("full_after_full", 64'(full), 0);
        drain(pops);
        chk("fill_drain_pops", 64'(pops), 129);
        chk("fill_drain_empty", 64'(empty), 1);
        chk("fill_sb_empty", 64'(sb.size()), 0);

        // Flush with 50 held and a read in flight
        for (int k = 0; k < 50; k++) begin
            step();
            wvalid = 1'b1;
            wdata = 32'h6000_0000 + 32'(k);
            rready = 1'b0;
            @(negedge clk);
        end
        step();
        wvalid = 1'b0;
        @(negedge clk);
        chk("pre_flush_level", 64'(level), 50);
        step();
        rready = 1'b1;
        @(negedge clk);
        chk("pre_flush_ren", 64'(bram_ren), 1);
        step();
        flush = 1'b1;
        rready = 1'b1;
        wvalid = 1'b1;
        wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        step();
        flush = 1'b0;
        rready = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("flush_level", 64'(level), 0);
        chk("flush_rvalid", 64'(rvalid), 0);
        chk("flush_empty", 64'(empty), 1);
        step();
        wvalid = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        chk("flush_push_waddr", 64'(bram_waddr), 0);
        step();
        wvalid = 1'b0;
        @(negedge clk);
        chk("flush_ren", 64'(bram_ren), 1);
        chk("flush_raddr", 64'(bram_raddr), 0);
        step();
        @(negedge clk);
        chk("flush_first_rvalid", 64'(rvalid), 1);
        chk("flush_first_rdata", 64'(rdata), 64'h1234);
        step();
        rready = 1'b1;
        @(negedge clk);
        step();
        rready = 1'b0;
        @(negedge clk);
        chk("final_empty", 64'(empty), 1);
        chk("final_sb_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Controller that turns one simple dual-port BRAM into a synchronous FIFO with valid/ready on both sides. The BRAM has a 1-cycle registered read that holds DOUT until its next REN.
- The block owns the write and read pointers, the occupancy count and read-issue sequencing. It hides BRAM read latency so a full stream moves 1 word/cycle.
- It sits between a producer/consumer pair and a BRAM instance that is external to this module.

Parameters:
DATAW, 32, data word width (must match the BRAM data width)
ADDRW, 7, BRAM address width
DEPTH, 128, BRAM entries; must equal 2**ADDRW

Ports:
Clk  in  1  clock; sole clock domain
Rest  in  1  reset; synchronous, active-high
Flush  in  1  synchronous clear of pointers, count and output slot
WValid  in  1  producer has a word
WData  in  DATAW  producer word
WReady  out  1  FIFO can accept a word
RValid  out  1  output word valid
RData  out  DATAW  output word
RReady  in  1  consumer takes the word
Level  out  ADDRW+1  total words held (BRAM plus output slot)
Empty  out  1  Level==0
Full  out  1  BRAM storage full (MemCnt==DEPTH)
BramRestN  out  1  active-low reset to BRAM; equals ~Rest
BramRen  out  1  BRAM read enable
BramWen  out  1  BRAM write enable
BramRaddr  out  ADDRW  BRAM read address
BramWaddr  out  ADDRW  BRAM write address
BramDin  out  DATAW  BRAM write data
BramDout  in  DATAW  BRAM registered read data

Behaviour:
- Internal state: WPtr, RPtr (ADDRW bits, wrap modulo DEPTH), MemCnt (0..DEPTH, words in BRAM not yet read), OutValid.
- Reset (Rest=1 at a Clk edge): WPtr=RPtr=0, MemCnt=0, OutValid=0.
  - Outputs during and after reset: WReady=0 while Rest=1, RValid=0, Level=0, Empty=1, Full=0, BramRen=BramWen=0.
  - A reset mid-stream drops all contents, including any read in flight.
- Push: Push = WValid & WReady.
  - WReady = ~Rest & (MemCnt != DEPTH). It depends only on registered state, with no same-cycle pop lookahead.
  - BramWen = Push; BramWaddr = WPtr; BramDin = WData.
  - On Push, WPtr increments.
- Pop: Pop = RValid & RReady. RValid = OutValid. RData = BramDout, passed through combinationally.
- Read issue: Issue = (MemCnt != 0) & (~OutValid | Pop).
  - BramRen = Issue; BramRaddr = RPtr.
  - On Issue, RPtr increments and OutValid is set next cycle.
  - If Pop occurs without Issue, OutValid clears next cycle.
  - The BRAM holds DOUT until its next REN. REN fires only when the slot is free or being vacated, so RData stays stable while RValid=1 and RReady=0.
- MemCnt update: next = MemCnt + Push - Issue.
  - Simultaneous push and issue leaves MemCnt unchanged.
  - Issue uses pre-edge MemCnt, so a word written in cycle N is readable no earlier than N+1. There is never a same-address read/write hazard.
- Latency: word pushed at edge N (FIFO empty) -> BramRen at N+1 -> RValid=1 after edge N+2.
- Throughput: 1 word/cycle sustained in and out once primed.
- Level = MemCnt + OutValid. Maximum is DEPTH+1: full BRAM plus one word in the output slot.
- Full/Empty:
  - At MemCnt==DEPTH, WReady=0 and pushes are ignored.
  - With MemCnt==0 and OutValid=0, RValid=0 and Empty=1.
- Pointer wrap: 127 -> 0 with no special handling. Pointer equality is never used; MemCnt alone distinguishes full from empty.
- Flush: same effect as reset on pointers, MemCnt and OutValid, except WReady is not forced low.
  - Push and Pop in the Flush cycle are discarded.
  - Flush has priority over all other updates.

Test Plan:
- Reset: hold Rest=1 for 3 cycles with WValid=1 -> WReady=0, RValid=0, Level=0, Empty=1, BramWen=0, BramRestN=0.
- Single word: push 0xA5A5_0001 at cycle 0 with RReady=0 -> BramRen=1 with Raddr=0 at cycle 1; RValid=1 with RData=0xA5A5_0001 from cycle 2; RData held stable for 5 stalled cycles; Level=1.
- Streaming: WValid=RReady=1 for 300 cycles with incrementing data -> output in order, no bubble after the first RValid, Level steady at 2, Raddr/Waddr wrap 127->0 correctly.
- Fill: push 130 words with RReady=0 -> exactly 129 accepted (128 in BRAM plus 1 in slot), Full=1, WReady=0, Level=129. Then RReady=1 -> 129 words drain in order, Empty=1 at the end.
- Simultaneous push/pop at Full: pop one word -> Issue that cycle, MemCnt goes 128->127, WReady=1 the next cycle, no data loss.
- Flush: assert Flush with Level=50 and a read in flight -> next cycle Level=0, RValid=0. A subsequent push of 0x1234 appears as the first output with 2-cycle latency.
